// File: rtl/iomem_router.sv
// iomem_router: address decoder and one-at-a-time transaction sequencer
// between the PicoSoC iomem master port and NSLAVES board peripherals.
//
// Requests in the BASE region select a peripheral slot from addr[19:16].
// Mapped slots get a held one-hot s_valid until s_ready. Unmapped slots get
// an immediate ERR_DATA response. The master sees a one-cycle iomem_ready
// pulse. Addresses outside BASE are ignored because other decoders own them.
//
// Handshake: s_valid[slot], s_wstrb, s_addr and s_wdata are registered and
// stay stable from the cycle s_valid rises until the cycle after the selected
// s_ready is sampled high. s_ready may be driven combinationally from s_valid.
// iomem_ready is high for exactly one cycle per completed request.
//
// Optional feature: define IOMEM_ROUTER_TIMEOUT_EN to build the peripheral
// timeout counter. Without it, BUSY waits for s_ready or for the master to
// abort, and the TIMEOUT parameter is unused.

module iomem_router #(
    parameter int unsigned NSLAVES  = 4,
    parameter logic [7:0]  BASE     = 8'h03,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    iomem_valid,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic                    iomem_ready,
    output logic [31:0]             iomem_rdata,
    output logic [NSLAVES-1:0]      s_valid,
    output logic [3:0]              s_wstrb,
    output logic [15:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic [NSLAVES-1:0]      s_ready,
    input  logic [32*NSLAVES-1:0]   s_rdata,
    output logic [7:0]              err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  iomem_ready_q, iomem_ready_d;
    logic [31:0]           iomem_rdata_q, iomem_rdata_d;
    logic [NSLAVES-1:0]    s_valid_q,     s_valid_d;
    logic [3:0]            s_wstrb_q,     s_wstrb_d;
    logic [15:0]           s_addr_q,      s_addr_d;
    logic [31:0]           s_wdata_q,     s_wdata_d;
    logic [7:0]            err_count_q,   err_count_d;
    logic [3:0]            slot_q,        slot_d;

    logic [3:0]            req_slot;
    logic                  region_hit;
    logic                  slot_mapped;
    logic                  accept;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  timeout_hit;
    logic [7:0]            err_count_inc;

    // Address bits between the slot field and the region byte are not decoded.
    logic                  addr_unused;
    assign addr_unused = ^iomem_addr[23:20];

    // Request decode. The !iomem_ready term keeps a request still held during
    // the response cycle from being taken a second time.
    assign req_slot    = iomem_addr[19:16];
    assign region_hit  = iomem_valid && (iomem_addr[31:24] == BASE) && !iomem_ready_q;
    assign slot_mapped = ({1'b0, req_slot} < 5'(NSLAVES));
    assign accept      = (state_q == ST_IDLE) && region_hit && slot_mapped;

    // Saturating increment for the error counter.
    assign err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : (err_count_q + 8'd1);

    // Select ready and read data of the latched slot; other slots are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < int'(NSLAVES); k++) begin
            if (slot_q == 4'(k)) begin
                sel_ready = s_ready[k];
                sel_rdata = s_rdata[32*k +: 32];
            end
        end
    end

`ifdef IOMEM_ROUTER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Timeout counter: cleared on accept, counts BUSY cycles without s_ready.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (accept) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ST_BUSY) && !sel_ready) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (tmo_cnt_q == 16'(TIMEOUT));
`else
    // No timeout hardware: BUSY only leaves on s_ready or abort.
    localparam logic [15:0] timeout_unused = 16'(TIMEOUT);
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In BUSY, peripheral completion beats timeout, and
    // both beat a master abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (region_hit) begin
                    state_d = slot_mapped ? ST_BUSY : ST_RESP;
                end
            end
            ST_BUSY: begin
                if (sel_ready) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                end else if (!iomem_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered bus outputs and counters.
    always_comb begin
        iomem_ready_d = 1'b0;
        iomem_rdata_d = iomem_rdata_q;
        s_valid_d     = s_valid_q;
        s_wstrb_d     = s_wstrb_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        err_count_d   = err_count_q;
        slot_d        = slot_q;
        case (state_q)
            ST_IDLE: begin
                if (region_hit) begin
                    if (slot_mapped) begin
                        slot_d    = req_slot;
                        s_wstrb_d = iomem_wstrb;
                        s_addr_d  = iomem_addr[15:0];
                        s_wdata_d = iomem_wdata;
                        s_valid_d = '0;
                        for (int k = 0; k < int'(NSLAVES); k++) begin
                            s_valid_d[k] = (req_slot == 4'(k));
                        end
                    end else begin
                        iomem_ready_d = 1'b1;
                        iomem_rdata_d = ERR_DATA;
                        err_count_d   = err_count_inc;
                    end
                end
            end
            ST_BUSY: begin
                if (sel_ready) begin
                    iomem_ready_d = 1'b1;
                    iomem_rdata_d = sel_rdata;
                    s_valid_d     = '0;
                end else if (timeout_hit) begin
                    iomem_ready_d = 1'b1;
                    iomem_rdata_d = ERR_DATA;
                    err_count_d   = err_count_inc;
                    s_valid_d     = '0;
                end else if (!iomem_valid) begin
                    s_valid_d     = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready_q <= 1'b0;
            iomem_rdata_q <= '0;
            s_valid_q     <= '0;
            s_wstrb_q     <= '0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            err_count_q   <= '0;
            slot_q        <= '0;
        end else begin
            iomem_ready_q <= iomem_ready_d;
            iomem_rdata_q <= iomem_rdata_d;
            s_valid_q     <= s_valid_d;
            s_wstrb_q     <= s_wstrb_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            err_count_q   <= err_count_d;
            slot_q        <= slot_d;
        end
    end

    assign iomem_ready = iomem_ready_q;
    assign iomem_rdata = iomem_rdata_q;
    assign s_valid     = s_valid_q;
    assign s_wstrb     = s_wstrb_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign err_count   = err_count_q;

endmodule
